// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-RAM arbiter between
// the fetch port and the load/store port.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  // Who owns the RAM read data that returns in the cycle after issue.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between core ports, arbiter and RAM macro. The slave modport
// is the arbiter's view; master is the core/RAM side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Handshake: a requester raises req with a stable command and holds it
  // until it sees a one-cycle gnt; reads return one cycle after gnt with a
  // one-cycle rvalid. Writes complete at the end of the gnt cycle.
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  ram_en;
  logic [DATA_W/8-1:0]   ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two RAM requesters.
// MEM_ARB_RR_EN: round-robin on conflict; otherwise data beats fetch.
module mem_arb_pick (
  input  logic if_elig,
  input  logic d_elig,
`ifdef MEM_ARB_RR_EN
  input  logic last_d,
`endif
  output logic pick_if,
  output logic pick_d
);

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On conflict the requester that did not win last time goes first.
    pick_d = d_elig & (~if_elig | ~last_d);
`else
    pick_d = d_elig;
`endif
    pick_if = if_elig & ~pick_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// data load/store. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  logic              if_gnt_q, d_gnt_q, ram_en_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [BE_W-1:0]   ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q, if_rdata_mux, d_rdata_mux;
  owner_e            owner_q;
  logic              if_elig, d_elig, pick_if, pick_d;

  // A requester whose grant is showing now has not yet dropped its request.
  assign if_elig = bus.if_req & ~if_gnt_q;
  assign d_elig  = bus.d_req & ~d_gnt_q;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  mem_arb_pick u_pick (
    .if_elig (if_elig),
    .d_elig  (d_elig),
    .last_d  (last_d_q),
    .pick_if (pick_if),
    .pick_d  (pick_d)
  );

  // Reset value 1 makes fetch the preferred side of the first conflict.
  always_ff @(posedge clk) begin
    if (!rst) last_d_q <= 1'b1;
    else if (pick_if | pick_d) last_d_q <= pick_d;
  end
`else
  mem_arb_pick u_pick (
    .if_elig (if_elig),
    .d_elig  (d_elig),
    .pick_if (pick_if),
    .pick_d  (pick_d)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      owner_q     <= OWN_NONE;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_gnt_q <= pick_if;
      d_gnt_q  <= pick_d;
      ram_en_q <= pick_if | pick_d;
      ram_we_q <= (pick_d && bus.d_we) ? bus.d_be : '0;
      if (pick_d) begin
        ram_addr_q  <= bus.d_addr;
        ram_wdata_q <= bus.d_wdata;
      end else if (pick_if) begin
        ram_addr_q  <= bus.if_addr;
      end
      if (pick_d)       owner_q <= bus.d_we ? OWN_NONE : OWN_D_RD;
      else if (pick_if) owner_q <= OWN_IF;
      else              owner_q <= OWN_NONE;
      if_rvalid_q <= (owner_q == OWN_IF);
      d_rvalid_q  <= (owner_q == OWN_D_RD);
      if_rdata_q  <= if_rdata_mux;
      d_rdata_q   <= d_rdata_mux;
    end
  end

  // RAM data flows straight through on the valid cycle, else last value holds.
  always_comb begin
    if_rdata_mux = if_rdata_q;
    d_rdata_mux  = d_rdata_q;
    if (if_rvalid_q) if_rdata_mux = bus.ram_rdata;
    if (d_rvalid_q)  d_rdata_mux  = bus.ram_rdata;
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_mux;
  assign bus.d_rdata   = d_rdata_mux;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, port drivers, cycle predictor and
// read-data scoreboard. Fetch uses words 0x00-0x1F, data uses 0x20-0x3F.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MEM_WORDS = 64;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] ram_mem [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] d_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port synchronous RAM, read-before-write, data one cycle after en.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < BE_W; b++)
        if (bus.ram_we[b]) ram_mem[bus.ram_addr[5:0]][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
      bus.ram_rdata <= ram_mem[bus.ram_addr[5:0]];
    end
  end

  // ---------------- drivers ----------------
  task automatic do_fetch(input logic [ADDR_W-1:0] a);
    int n = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 40);
    if (!bus.if_gnt) check("if_gnt_timeout", bus.if_gnt, 1'b1);
    else if_exp_q.push_back(ref_mem[a[5:0]]);
    bus.if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    int n = 0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = a; bus.d_wdata = wd;
    do begin @(negedge clk); n++; end while (!bus.d_gnt && n < 40);
    if (!bus.d_gnt) check("d_gnt_timeout", bus.d_gnt, 1'b1);
    else if (we) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) ref_mem[a[5:0]][b*8 +: 8] = wd[b*8 +: 8];
    end else d_exp_q.push_back(ref_mem[a[5:0]]);
    bus.d_req = 1'b0;
  endtask

  // Both ports hold read requests for n cycles; every grant is a read.
  task automatic hold_both(input int n, input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                           output int nif, output int nd, output int nen,
                           output logic first_d, output logic first_en);
    nif = 0; nd = 0; nen = 0; first_d = 1'b0; first_en = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = ia;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = da;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin first_d = bus.d_gnt; first_en = bus.ram_en; end
      if (bus.if_gnt) begin nif++; if_exp_q.push_back(ref_mem[ia[5:0]]); end
      if (bus.d_gnt)  begin nd++;  d_exp_q.push_back(ref_mem[da[5:0]]); end
      nen += int'(bus.ram_en);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  // ---------------- monitor / predictor ----------------
  logic e_rst, e_if_req, e_d_req, e_d_we;
  logic [BE_W-1:0]   e_d_be;
  logic [ADDR_W-1:0] e_if_addr, e_d_addr;
  logic [DATA_W-1:0] e_d_wdata;
  logic el_if, el_d, w_if, w_d;
  logic p_if_gnt = 1'b0, p_d_gnt = 1'b0, p_d_rd = 1'b0, last_d = 1'b1;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] hold_if = '0, hold_d = '0;
  int n_if_rv = 0, n_d_rv = 0;

  always begin
    @(posedge clk);
    e_rst = rst; e_if_req = bus.if_req; e_if_addr = bus.if_addr;
    e_d_req = bus.d_req; e_d_we = bus.d_we; e_d_be = bus.d_be;
    e_d_addr = bus.d_addr; e_d_wdata = bus.d_wdata;
    #2;
    el_if = e_if_req && !p_if_gnt;
    el_d  = e_d_req && !p_d_gnt;
    if (el_if && el_d) w_d = RR_MODE ? !last_d : 1'b1;
    else w_d = el_d;
    w_if = el_if && !w_d;
    if (!e_rst) begin w_if = 1'b0; w_d = 1'b0; end
    if (!e_rst) exp_addr = '0;
    else if (w_d) exp_addr = e_d_addr;
    else if (w_if) exp_addr = e_if_addr;

    check("if_gnt", bus.if_gnt, w_if);
    check("d_gnt", bus.d_gnt, w_d);
    check("ram_en", bus.ram_en, w_if || w_d);
    check("ram_we", bus.ram_we, (w_d && e_d_we) ? e_d_be : '0);
    check("ram_addr", bus.ram_addr, exp_addr);
    if (w_d && e_d_we) check("ram_wdata", bus.ram_wdata, e_d_wdata);
    if (!e_rst) check("rst_ram_wdata", bus.ram_wdata, '0);
    check("if_rvalid", bus.if_rvalid, e_rst && p_if_gnt);
    check("d_rvalid", bus.d_rvalid, e_rst && p_d_rd);

    if (!e_rst) begin hold_if = '0; hold_d = '0; end
    if (e_rst && p_if_gnt && bus.if_rvalid) begin
      check("if_exp_avail", if_exp_q.size() != 0, 1'b1);
      if (if_exp_q.size() != 0) hold_if = if_exp_q.pop_front();
    end
    if (e_rst && p_d_rd && bus.d_rvalid) begin
      check("d_exp_avail", d_exp_q.size() != 0, 1'b1);
      if (d_exp_q.size() != 0) hold_d = d_exp_q.pop_front();
    end
    check("if_rdata", bus.if_rdata, hold_if);
    check("d_rdata", bus.d_rdata, hold_d);

    n_if_rv += int'(bus.if_rvalid);
    n_d_rv  += int'(bus.d_rvalid);
    p_if_gnt = w_if;
    p_d_gnt  = w_d;
    p_d_rd   = w_d && !e_d_we;
    if (!e_rst) last_d = 1'b1;
    else if (w_if || w_d) last_d = w_d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int nif, nd, nen, cnt_if, cnt_d;
    logic first_d, first_en;

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram_mem[i] = 32'h3C00_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[16] = 32'h2402_000A; ref_mem[16] = 32'h2402_000A;
    ram_mem[32] = 32'h1111_1111; ref_mem[32] = 32'h1111_1111;

    bus.if_req = 1'b1; bus.if_addr = 14'h00;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = 14'h21; bus.d_wdata = '0;
    rst = 1'b0;

    // Reset held with both requests pending.
    repeat (3) @(negedge clk);
    check("rst_ram_en", bus.ram_en, 1'b0);
    check("rst_gnts", {bus.if_gnt, bus.d_gnt}, 2'b00);
    rst = 1'b1;
    hold_both(2, 14'h00, 14'h21, nif, nd, nen, first_d, first_en);
    check("rel_first_ram_en", first_en, 1'b1);
    check("rel_first_is_d", first_d, !RR_MODE);
    check("rel_grants", {nif[7:0], nd[7:0]}, 16'h0101);
    repeat (2) @(negedge clk);

    // Single fetch.
    do_fetch(14'h10);
    check("fetch_ram_addr", bus.ram_addr, 14'h10);
    @(negedge clk);
    check("fetch_rvalid", bus.if_rvalid, 1'b1);
    check("fetch_rdata", bus.if_rdata, 32'h2402_000A);
    repeat (2) @(negedge clk);

    // Partial write then read-back.
    cnt_if = n_if_rv;
    do_data(1'b1, 4'b0011, 14'h20, 32'hDEAD_BEEF);
    check("wr_ram_we", bus.ram_we, 4'b0011);
    @(negedge clk);
    do_data(1'b0, 4'b0000, 14'h20, 32'h0);
    repeat (2) @(negedge clk);
    check("rd_merge", bus.d_rdata, 32'h1111_BEEF);
    check("rd_no_if_rvalid", n_if_rv - cnt_if, 0);
    repeat (2) @(negedge clk);

    // Conflict right after a data grant.
    hold_both(2, 14'h12, 14'h23, nif, nd, nen, first_d, first_en);
    check("conflict_first_is_d", first_d, !RR_MODE);
    check("conflict_grants", {nif[7:0], nd[7:0]}, 16'h0101);
    repeat (2) @(negedge clk);

    // Back-to-back: both held for ten cycles.
    hold_both(10, 14'h13, 14'h24, nif, nd, nen, first_d, first_en);
    check("b2b_if_grants", nif, 5);
    check("b2b_d_grants", nd, 5);
    check("b2b_ram_en_cycles", nen, 10);
    repeat (3) @(negedge clk);

    // Reset arriving before the read data returns.
    cnt_d = n_d_rv;
    do_data(1'b0, 4'b0000, 14'h22, 32'h0);
    rst = 1'b0;
    d_exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_discards_read", n_d_rv - cnt_d, 0);

    // Randomized concurrent traffic.
    fork
      for (int i = 0; i < 60; i++) begin
        do_fetch(ADDR_W'($urandom_range(0, 31)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < 60; i++) begin
        do_data(1'($urandom_range(0, 1)), BE_W'($urandom_range(0, 15)),
                ADDR_W'(32 + $urandom_range(0, 31)), $urandom());
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join
    repeat (4) @(negedge clk);
    check("if_q_drained", if_exp_q.size(), 0);
    check("d_q_drained", d_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
